// File: rtl/dcache_port_arb_pkg.sv
// Shared definitions for the data-cache port arbiter.
//   PA_W            physical address width of the cache port
//   arb_state_e     one-hot arbiter state encoding
//   SIZE_*          request size encodings, shared with the TLB stage reqSize
package dcache_port_arb_pkg;

    localparam int PA_W = 15;

    typedef enum logic [3:0] {
        ARB_IDLE = 4'b0001,
        ARB_LD1  = 4'b0010,
        ARB_LD2  = 4'b0100,
        ARB_ST   = 4'b1000
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

endpackage

// File: rtl/dcache_port_arb_starve_ctr.sv
// Saturating count of load grants handed out while a store is waiting.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   inc        count one more load grant (ignored once saturated)
//   clr        return the count to zero (wins over inc)
//   at_max     count has reached MAX; the waiting store must be forced
module arb_starve_ctr #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/dcache_port_arb.sv
// Arbitrates the single data-cache request port between TLB-stage loads
// (one or two beats) and writeback-stage stores. The winning request is
// registered onto the cache port and held until the cache accepts it.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ld_req/ld_addr1/ld_addr2/
//   ld_size1/ld_size2/ld_spill   load request; addr2/size2 used on spill
//   ld_ack                       final load beat accepted (pulse)
//   st_req/st_addr/st_size/
//   st_data/st_urgent            store request; urgent forces next win
//   st_ack                       store accepted (pulse)
//   flush                        global invalidate, cancels loads only
//   c_valid/c_addr/c_size/
//   c_wen/c_wdata/c_ready        registered cache request port
//   busy                         arbiter not idle
//
// state    | meaning
// ---------+-------------------------------------------------------
// ARB_IDLE | port free, arbitrating this cycle
// ARB_LD1  | load beat 1 presented, waiting for c_ready
// ARB_LD2  | load beat 2 presented, port locked against stores
// ARB_ST   | store presented, waiting for c_ready
module dcache_port_arb
    import dcache_port_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int STARVE_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_req,
    input  logic [PA_W-1:0] ld_addr1,
    input  logic [PA_W-1:0] ld_addr2,
    input  logic [1:0]      ld_size1,
    input  logic [1:0]      ld_size2,
    input  logic            ld_spill,
    output logic            ld_ack,
    input  logic            st_req,
    input  logic [PA_W-1:0] st_addr,
    input  logic [1:0]      st_size,
    input  logic [31:0]     st_data,
    input  logic            st_urgent,
    output logic            st_ack,
    input  logic            flush,
    output logic            c_valid,
    output logic [PA_W-1:0] c_addr,
    output logic [1:0]      c_size,
    output logic            c_wen,
    output logic [31:0]     c_wdata,
    input  logic            c_ready,
    output logic            busy
);

    arb_state_e state;
    arb_state_e state_nxt;

    logic            spill_q;
    logic            spill_d;
    logic            c_valid_d;
    logic [PA_W-1:0] c_addr_d;
    logic [1:0]      c_size_d;
    logic            c_wen_d;
    logic [31:0]     c_wdata_d;

    logic pick_st;
    logic pick_ld;
    logic starve_inc;
    logic starve_clr;
    logic starve_at_max;

    // Store wins when forced (urgent or starved) or when no load competes.
    // A flush only suppresses loads, so it never appears in the store term.
    assign pick_st = st_req && (st_urgent || starve_at_max || !ld_req);
    assign pick_ld = !pick_st && ld_req && !flush;

    assign starve_inc = (state == ARB_IDLE) && pick_ld && st_req;
    assign starve_clr = (state == ARB_IDLE) && (pick_st || !st_req);

    arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (STARVE_W)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (pick_st) begin
                    state_nxt = ARB_ST;
                end else if (pick_ld) begin
                    state_nxt = ARB_LD1;
                end
            end
            ARB_LD1: begin
                if (flush) begin
                    state_nxt = ARB_IDLE;
                end else if (c_ready) begin
                    state_nxt = spill_q ? ARB_LD2 : ARB_IDLE;
                end
            end
            ARB_LD2: begin
                if (flush || c_ready) begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_ST: begin
                if (c_ready) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Next values for the registered port plus the decoded ack pulses.
    // c_valid is 1 in every non-idle state, so c_ready alone marks a beat
    // as accepted there.
    always_comb begin
        c_valid_d = c_valid;
        c_addr_d  = c_addr;
        c_size_d  = c_size;
        c_wen_d   = c_wen;
        c_wdata_d = c_wdata;
        spill_d   = spill_q;
        ld_ack    = 1'b0;
        st_ack    = 1'b0;
        case (state)
            ARB_IDLE: begin
                c_valid_d = pick_st || pick_ld;
                if (pick_st) begin
                    c_wen_d   = 1'b1;
                    c_addr_d  = st_addr;
                    c_size_d  = st_size;
                    c_wdata_d = st_data;
                end else if (pick_ld) begin
                    c_wen_d  = 1'b0;
                    c_addr_d = ld_addr1;
                    c_size_d = ld_size1;
                    spill_d  = ld_spill;
                end
            end
            ARB_LD1: begin
                if (flush) begin
                    c_valid_d = 1'b0;
                end else if (c_ready) begin
                    if (spill_q) begin
                        // Beat 2 follows directly; c_valid stays high.
                        c_addr_d = ld_addr2;
                        c_size_d = ld_size2;
                    end else begin
                        c_valid_d = 1'b0;
                        ld_ack    = 1'b1;
                    end
                end
            end
            ARB_LD2: begin
                if (flush) begin
                    c_valid_d = 1'b0;
                end else if (c_ready) begin
                    c_valid_d = 1'b0;
                    ld_ack    = 1'b1;
                end
            end
            ARB_ST: begin
                if (c_ready) begin
                    c_valid_d = 1'b0;
                    st_ack    = 1'b1;
                end
            end
            default: c_valid_d = 1'b0;
        endcase
        // A reset abandons whatever is on the port without acknowledging it.
        if (rst) begin
            ld_ack = 1'b0;
            st_ack = 1'b0;
        end
    end

    assign busy = (state != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_addr  <= '0;
            c_size  <= '0;
            c_wen   <= 1'b0;
            c_wdata <= '0;
            spill_q <= 1'b0;
        end else begin
            c_valid <= c_valid_d;
            c_addr  <= c_addr_d;
            c_size  <= c_size_d;
            c_wen   <= c_wen_d;
            c_wdata <= c_wdata_d;
            spill_q <= spill_d;
        end
    end

endmodule

// File: tb/tb_dcache_port_arb.sv
`timescale 1ns/1ps
module tb_dcache_port_arb;
    import dcache_port_arb_pkg::*;

    localparam int SMAX = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ld_req = 1'b0;
    logic [PA_W-1:0] ld_addr1 = '0;
    logic [PA_W-1:0] ld_addr2 = '0;
    logic [1:0]      ld_size1 = '0;
    logic [1:0]      ld_size2 = '0;
    logic            ld_spill = 1'b0;
    logic            ld_ack;
    logic            st_req = 1'b0;
    logic [PA_W-1:0] st_addr = '0;
    logic [1:0]      st_size = '0;
    logic [31:0]     st_data = '0;
    logic            st_urgent = 1'b0;
    logic            st_ack;
    logic            flush = 1'b0;
    logic            c_valid;
    logic [PA_W-1:0] c_addr;
    logic [1:0]      c_size;
    logic            c_wen;
    logic [31:0]     c_wdata;
    logic            c_ready = 1'b0;
    logic            busy;

    always #5 clk = ~clk;

    dcache_port_arb #(.STARVE_MAX(SMAX), .STARVE_W(3)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr1(ld_addr1), .ld_addr2(ld_addr2),
        .ld_size1(ld_size1), .ld_size2(ld_size2), .ld_spill(ld_spill), .ld_ack(ld_ack),
        .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
        .st_urgent(st_urgent), .st_ack(st_ack), .flush(flush),
        .c_valid(c_valid), .c_addr(c_addr), .c_size(c_size), .c_wen(c_wen),
        .c_wdata(c_wdata), .c_ready(c_ready), .busy(busy)
    );

    typedef struct {
        logic [PA_W-1:0] a1;
        logic [PA_W-1:0] a2;
        logic [1:0]      s1;
        logic [1:0]      s2;
        logic            spill;
    } ld_txn_t;

    typedef struct {
        logic [PA_W-1:0] addr;
        logic [1:0]      size;
        logic [31:0]     data;
    } st_txn_t;

    ld_txn_t ld_q[$];
    st_txn_t st_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_ld(input logic [PA_W-1:0] a1, input logic [PA_W-1:0] a2,
                            input logic [1:0] s1, input logic [1:0] s2, input logic sp);
        ld_txn_t t;
        ld_req = 1'b1; ld_addr1 = a1; ld_addr2 = a2;
        ld_size1 = s1; ld_size2 = s2; ld_spill = sp;
        t.a1 = a1; t.a2 = a2; t.s1 = s1; t.s2 = s2; t.spill = sp;
        ld_q.push_back(t);
    endtask

    task automatic issue_st(input logic [PA_W-1:0] a, input logic [1:0] s,
                            input logic [31:0] d, input logic urg);
        st_txn_t t;
        st_req = 1'b1; st_addr = a; st_size = s; st_data = d; st_urgent = urg;
        t.addr = a; t.size = s; t.data = d;
        st_q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic        prev_valid = 1'b0, prev_hold = 1'b0, prev_mid = 1'b0;
    logic        prev_ld = 1'b0, prev_st = 1'b0, prev_urg = 1'b0, prev_fl = 1'b0;
    logic [50:0] prev_bus = '0;
    int          starve_m = 0;
    int          beat = 0;

    always @(negedge clk) begin
        logic        acc, fin, exp_lack, want_st, want_ld;
        logic [50:0] bus;
        ld_txn_t     lt;
        st_txn_t     stt;
        bus = {c_valid, c_addr, c_size, c_wen, c_wdata};
        fin = 1'b0;
        exp_lack = 1'b0;
        if (rst) begin
            ld_q.delete();
            st_q.delete();
            beat = 0; starve_m = 0;
            prev_valid = 1'b0; prev_hold = 1'b0; prev_mid = 1'b0;
            prev_ld = 1'b0; prev_st = 1'b0; prev_urg = 1'b0; prev_fl = 1'b0;
        end else begin
            if (prev_hold) chk("hold_stable", bus, prev_bus);
            if (prev_mid) chk("spill_no_bubble", {c_valid, c_wen}, 2'b10);
            // Previous cycle was idle: predict the arbitration outcome.
            if (!prev_valid) begin
                want_st = prev_st && (prev_urg || starve_m == SMAX || !prev_ld);
                want_ld = !want_st && prev_ld && !prev_fl;
                chk("grant_valid", c_valid, want_st || want_ld);
                if (want_st || want_ld) chk("grant_type", c_wen, want_st);
                if (want_st) starve_m = 0;
                else if (want_ld) starve_m = prev_st ? ((starve_m < SMAX) ? starve_m + 1 : SMAX) : 0;
                else if (!prev_st) starve_m = 0;
            end
            acc = c_valid && c_ready && !(flush && !c_wen);
            if (acc && c_wen) begin
                chk("st_outstanding", st_q.size() != 0, 1'b1);
                if (st_q.size() != 0) begin
                    stt = st_q.pop_front();
                    chk("st_beat", {c_addr, c_size, c_wdata}, {stt.addr, stt.size, stt.data});
                end
            end
            if (st_ack || (acc && c_wen)) chk("st_ack", st_ack, acc && c_wen);
            if (acc && !c_wen) begin
                chk("ld_outstanding", ld_q.size() != 0, 1'b1);
                if (ld_q.size() != 0) begin
                    lt = ld_q[0];
                    chk("ld_beat", {c_addr, c_size},
                        (beat == 0) ? {lt.a1, lt.s1} : {lt.a2, lt.s2});
                    fin = (beat == 1) || !lt.spill;
                    exp_lack = fin;
                    if (fin) begin
                        ld_q.delete(0);
                        beat = 0;
                    end else begin
                        beat = 1;
                    end
                end
            end
            if (ld_ack || exp_lack) chk("ld_ack", ld_ack, exp_lack);
            // A flush cancels whatever load the requester is holding.
            if (flush && ld_req) begin
                if (ld_q.size() != 0) ld_q.delete(0);
                beat = 0;
            end
            prev_valid = c_valid;
            prev_hold  = c_valid && !c_ready && !(flush && !c_wen);
            prev_mid   = acc && !c_wen && !fin && (beat == 1);
            prev_bus   = bus;
            prev_ld = ld_req; prev_st = st_req; prev_urg = st_urgent; prev_fl = flush;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic la, sa, fl, done;
        int   grants;
        logic [PA_W-1:0] ra1, ra2, rsa;
        logic [1:0]      rs1, rs2, rss;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {c_valid, c_wen, c_addr, c_size, c_wdata, ld_ack, st_ack, busy}, 64'd0);
        step();
        rst = 1'b0;

        // single load, 1-cycle latency
        step();
        c_ready = 1'b1;
        issue_ld(15'h1234, 15'h0, SIZE_WORD, SIZE_BYTE, 1'b0);
        @(negedge clk); chk("t1_lat0", c_valid, 1'b0);
        step();
        @(negedge clk);
        chk("t1_beat", {c_valid, c_addr, c_wen}, {1'b1, 15'h1234, 1'b0});
        chk("t1_ack", {ld_ack, busy}, 2'b11);
        step();
        ld_req = 1'b0;
        @(negedge clk); chk("t1_busy_drop", {busy, c_valid}, 2'b00);

        // spilled load with beat 1 stalled two cycles
        step();
        c_ready = 1'b0;
        issue_ld(15'h0FFC, 15'h1000, SIZE_WORD, SIZE_HALF, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_beat1", {c_valid, c_addr, ld_ack}, {1'b1, 15'h0FFC, 1'b0});
            step();
            if (k == 1) c_ready = 1'b1;
        end
        @(negedge clk);
        chk("t2_beat2", {c_valid, c_addr, c_size, ld_ack}, {1'b1, 15'h1000, SIZE_HALF, 1'b1});
        step();
        ld_req = 1'b0; c_ready = 1'b0;
        @(negedge clk); chk("t2_idle", {c_valid, ld_ack}, 2'b00);

        // urgent store raised during beat 1 must wait for beat 2
        step();
        issue_ld(15'h0100, 15'h0104, SIZE_WORD, SIZE_WORD, 1'b1);
        step();
        issue_st(15'h2000, SIZE_WORD, 32'hDEADBEEF, 1'b1);
        @(negedge clk); chk("t3_ld1_a", {c_wen, c_addr}, {1'b0, 15'h0100});
        step();
        @(negedge clk); chk("t3_ld1_b", {c_wen, c_addr}, {1'b0, 15'h0100});
        step();
        c_ready = 1'b1;
        @(negedge clk); chk("t3_ld1_c", {c_wen, c_addr, st_ack}, {1'b0, 15'h0100, 1'b0});
        step();
        @(negedge clk); chk("t3_ld2", {c_wen, c_addr, ld_ack, st_ack}, {1'b0, 15'h0104, 1'b1, 1'b0});
        step();
        ld_req = 1'b0;
        @(negedge clk); chk("t3_gap", c_valid, 1'b0);
        step();
        @(negedge clk);
        chk("t3_store", {c_valid, c_wen, c_wdata, st_ack}, {1'b1, 1'b1, 32'hDEADBEEF, 1'b1});
        step();
        st_req = 1'b0; st_urgent = 1'b0;

        // starvation: exactly SMAX load grants, then the store; twice in a row
        step();
        c_ready = 1'b1;
        issue_ld(15'h0400, 15'h0, SIZE_WORD, SIZE_WORD, 1'b0);
        issue_st(15'h0500, SIZE_WORD, 32'hA5A50001, 1'b0);
        for (int r = 0; r < 2; r++) begin
            grants = 0;
            done = 1'b0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge clk);
                la = ld_ack; sa = st_ack;
                if (la) grants++;
                step();
                if (la) issue_ld(15'h0400 + 15'(grants), 15'h0, SIZE_WORD, SIZE_WORD, 1'b0);
                if (sa) begin
                    done = 1'b1;
                    if (r == 0) issue_st(15'h0501, SIZE_WORD, 32'hA5A50002, 1'b0);
                    else st_req = 1'b0;
                end
            end
            chk("t4_store_done", done, 1'b1);
            chk("t4_load_grants", grants, SMAX);
        end
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            la = ld_ack;
            step();
            if (la) begin
                ld_req = 1'b0;
                done = 1'b1;
            end
        end
        chk("t4_tail_ack", done, 1'b1);

        // flush during beat 2 with c_ready high
        step();
        c_ready = 1'b1;
        issue_ld(15'h0800, 15'h0804, SIZE_WORD, SIZE_WORD, 1'b1);
        step();
        @(negedge clk); chk("t5_beat1", {c_valid, c_addr}, {1'b1, 15'h0800});
        step();
        flush = 1'b1;
        @(negedge clk); chk("t5_flush_noack", {c_valid, c_addr, ld_ack}, {1'b1, 15'h0804, 1'b0});
        step();
        flush = 1'b0; ld_req = 1'b0;
        @(negedge clk); chk("t5_flushed_idle", {c_valid, busy}, 2'b00);
        // flush during a store does not disturb it
        c_ready = 1'b0;
        issue_st(15'h0900, SIZE_HALF, 32'h12345678, 1'b0);
        step();
        @(negedge clk); chk("t5_st", {c_valid, c_wen}, 2'b11);
        step();
        flush = 1'b1; c_ready = 1'b1;
        @(negedge clk); chk("t5_st_ack", st_ack, 1'b1);
        step();
        flush = 1'b0; st_req = 1'b0; c_ready = 1'b0;
        @(negedge clk); chk("t5_st_done", c_valid, 1'b0);

        // reset while a store is held
        step();
        issue_st(15'h0A00, SIZE_WORD, 32'hCAFEF00D, 1'b0);
        step();
        @(negedge clk); chk("t6_st_held", {c_valid, c_wen}, 2'b11);
        step();
        rst = 1'b1; st_req = 1'b0; c_ready = 1'b1;
        @(negedge clk); chk("t6_rst_noack", st_ack, 1'b0);
        step();
        rst = 1'b0; c_ready = 1'b0;
        @(negedge clk); chk("t6_after_rst", {c_valid, busy, st_ack}, 3'b000);

        // randomized traffic
        step();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            la = ld_ack; sa = st_ack; fl = flush;
            step();
            if (ld_req && (la || fl)) ld_req = 1'b0;
            if (st_req && sa) begin
                st_req = 1'b0;
                st_urgent = 1'b0;
            end
            if (!ld_req && $urandom_range(2) == 0) begin
                ra1 = PA_W'($urandom); ra2 = PA_W'($urandom);
                rs1 = 2'($urandom); rs2 = 2'($urandom);
                issue_ld(ra1, ra2, rs1, rs2, 1'($urandom_range(1)));
            end
            if (!st_req && $urandom_range(3) == 0) begin
                rsa = PA_W'($urandom); rss = 2'($urandom);
                issue_st(rsa, rss, $urandom, $urandom_range(3) == 0);
            end
            flush = ($urandom_range(15) == 0);
            c_ready = ($urandom_range(9) < 6);
        end

        // drain
        flush = 1'b0;
        c_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            la = ld_ack; sa = st_ack; fl = flush;
            step();
            if (ld_req && (la || fl)) ld_req = 1'b0;
            if (st_req && sa) begin
                st_req = 1'b0;
                st_urgent = 1'b0;
            end
            if (!ld_req && !st_req) done = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("drain_done", done, 1'b1);
        chk("drain_ld_q", ld_q.size(), 0);
        chk("drain_st_q", st_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
